// File: rtl/filter_stream_pkg.sv
// Shared types and the RGB444 pixel filter used by the frame-scan controller
// and the grayscale_filter datapath.
package filter_stream_pkg;

  typedef enum logic [1:0] {
    BYPASS   = 2'b00,
    GRAY     = 2'b01,
    INVERT   = 2'b10,
    GRAY_INV = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int PIX_W  = 12;
  localparam int FIFO_W = PIX_W + 2;

  // Grayscale is (max+min)/2 on a 5-bit sum; invert is applied after grayscale.
  function automatic rgb444_t filter_pixel(input mode_e mode, input rgb444_t p);
    logic [3:0] mx;
    logic [3:0] mn;
    logic [4:0] sum;
    rgb444_t    q;
    mx = p.r;
    if (p.g > mx) mx = p.g;
    if (p.b > mx) mx = p.b;
    mn = p.r;
    if (p.g < mn) mn = p.g;
    if (p.b < mn) mn = p.b;
    sum = {1'b0, mx} + {1'b0, mn};
    q = p;
    if (mode == GRAY || mode == GRAY_INV) q = '{r: sum[4:1], g: sum[4:1], b: sum[4:1]};
    if (mode == INVERT || mode == GRAY_INV) q = '{r: 4'd15 - q.r, g: 4'd15 - q.g, b: 4'd15 - q.b};
    return q;
  endfunction

endpackage

// File: rtl/filter_stream_ctrl_fifo.sv
// Synchronous show-ahead FIFO holding filtered pixels with their sof/eol tags.
module pixel_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && (count != CNT_FULL);
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage carries no reset; only pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/filter_stream_ctrl.sv
// Frame-scan controller: reads a frame in raster order, filters each pixel
// and streams it out on valid/ready with sof/eol markers.
module filter_stream_ctrl
  import filter_stream_pkg::*;
#(
  parameter int H_PIX      = 320,
  parameter int V_PIX      = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode_sel,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_rdata,
  output logic [11:0]       pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol
);

  localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [XW-1:0]     X_LAST  = XW'(H_PIX - 1);
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(H_PIX * V_PIX - 1);
  localparam logic [CW:0]       CREDITS = (CW+1)'(FIFO_DEPTH);

  state_e           state;
  mode_e            mode_q;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             inflight;
  logic             sof_d;
  logic             eol_d;
  logic [CW:0]      fifo_count;
  logic [FIFO_W-1:0] fifo_head;
  rgb444_t          filt;
  logic             fifo_rd;
  logic             last_hs;

  assign busy = (state != IDLE);

  // A read is only issued if its word is guaranteed a FIFO slot on return.
  assign mem_en = (state == RUN) && ((fifo_count + (CW+1)'(inflight)) < CREDITS);

  assign filt      = filter_pixel(mode_q, rgb444_t'(mem_rdata));
  assign pix_valid = (fifo_count != '0);
  assign {pix_out, pix_sof, pix_eol} = pix_valid ? fifo_head : '0;
  assign fifo_rd   = pix_valid && pix_ready;

  // In DRAIN with nothing in flight, the single remaining entry is the last pixel.
  assign last_hs = (state == DRAIN) && !inflight && (fifo_count == (CW+1)'(1)) && pix_ready;

  pixel_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight),
    .wr_data ({filt, sof_d, eol_d}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= BYPASS;
      mem_addr <= '0;
      x        <= '0;
      y        <= '0;
      inflight <= 1'b0;
      sof_d    <= 1'b0;
      eol_d    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= mem_en;
      unique case (state)
        IDLE: if (start) begin
          state    <= RUN;
          mode_q   <= mode_e'(mode_sel);
          mem_addr <= '0;
          x        <= '0;
          y        <= '0;
        end
        RUN: if (mem_en) begin
          sof_d    <= (x == '0) && (y == '0);
          eol_d    <= (x == X_LAST);
          mem_addr <= mem_addr + 1'b1;
          if (x == X_LAST) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
          if (mem_addr == A_LAST) state <= DRAIN;
        end
        DRAIN: if (last_hs) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Scoreboard bench for filter_stream_ctrl on a 4x2 frame with a behavioural filter model.
`timescale 1ns/1ps
module tb_filter_stream_ctrl;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;
  localparam int DEPTH = 4;
  localparam int AW = 17;

  typedef struct {
    logic [11:0] pix;
    logic        sof;
    logic        eol;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode_sel;
  logic          busy, done, mem_en;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_rdata;
  logic [11:0]   pix_out;
  logic          pix_valid, pix_ready, pix_sof, pix_eol;

  logic [11:0] ram [N];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          issued = 0;
  int          taken = 0;
  logic        exp_done = 1'b0;
  logic        mon_on = 1'b0;

  filter_stream_ctrl #(
    .H_PIX(H), .V_PIX(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .pix_out(pix_out), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr[2:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference filter written from the channel rules with plain integers.
  function automatic logic [11:0] ref_filter(input int mode, input logic [11:0] w);
    int r, g, b, mx, mn;
    r = int'(w[11:8]);
    g = int'(w[7:4]);
    b = int'(w[3:0]);
    mx = (r > g) ? r : g;
    mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g;
    mn = (mn < b) ? mn : b;
    if (mode == 1 || mode == 3) begin
      r = (mx + mn) / 2;
      g = r;
      b = r;
    end
    if (mode == 2 || mode == 3) begin
      r = 15 - r;
      g = 15 - g;
      b = 15 - b;
    end
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  // Monitor: pops the scoreboard on every handshake and tracks done/addr/credit rules.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_on) begin
      issued   = 0;
      taken    = 0;
      exp_done = 1'b0;
    end else begin
      check("done_timing", 32'(done), 32'(exp_done));
      exp_done = 1'b0;
      check("outstanding_le_depth", 32'(issued - taken <= DEPTH), 32'd1);
      if (mem_en) begin
        check("mem_addr", 32'(mem_addr), 32'(issued));
        issued++;
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 32'(pix_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'({pix_out, pix_sof, pix_eol}), 32'({e.pix, e.sof, e.eol}));
          taken++;
          if (e.last) begin
            exp_done = 1'b1;
            issued   = 0;
            taken    = 0;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_sof", 32'(pix_sof), 32'd0);
    check("rst_pix_eol", 32'(pix_eol), 32'd0);
    check("rst_pix_out", 32'(pix_out), 32'd0);
  endtask

  // rmode: 0 ready held high, 1 random ready, 2 ten-cycle stall mid-frame.
  // Must be called at a negedge; returns at the negedge where done is seen.
  task automatic run_frame(input logic [1:0] mode, input int rmode, input bit wiggle, input bit restart);
    int t0;
    bit seen = 0;
    bit got = 0;
    bit held_v = 0;
    logic [13:0] held = '0;
    for (int i = 0; i < N; i++)
      exp_q.push_back('{pix: ref_filter(int'(mode), ram[i]), sof: (i == 0),
                        eol: ((i % H) == H - 1), last: (i == N - 1)});
    start    = 1'b1;
    mode_sel = mode;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
    if (wiggle) mode_sel = 2'($urandom);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    check("first_mem_en", 32'(mem_en), 32'd1);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      start = restart && (n == 3);
      if (wiggle) mode_sel = 2'($urandom);
      case (rmode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'($urandom);
        default: pix_ready = !(n >= 2 && n < 12);
      endcase
      @(negedge clk);
      if (!seen && pix_valid) begin
        seen = 1;
        check("first_valid_latency", 32'(cyc - t0), 32'd2);
      end
      if (rmode == 2 && n >= 2 && n < 12) begin
        if (held_v) check("stall_hold", 32'({pix_valid, pix_out, pix_sof, pix_eol}), 32'({1'b1, held}));
        if (n >= 8) check("stall_mem_en_off", 32'(mem_en), 32'd0);
        held   = {pix_out, pix_sof, pix_eol};
        held_v = pix_valid;
      end
      if (done) begin
        got = 1;
        check("busy_low_at_done", 32'(busy), 32'd0);
        break;
      end
    end
    check("frame_completed", 32'(got), 32'd1);
    check("saw_valid", 32'(seen), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    pix_ready = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode_sel = 2'b00;
    pix_ready = 1'b1;
    for (int i = 0; i < N; i++) ram[i] = 12'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    // Bypass, ready held high, RAM holds word i at address i.
    run_frame(2'b00, 0, 1'b0, 1'b0);

    // Grayscale directed words, then grayscale+invert.
    ram[0] = 12'hF30; ram[1] = 12'h000; ram[2] = 12'hFFF; ram[3] = 12'h1E7;
    for (int i = 4; i < N; i++) ram[i] = 12'($urandom);
    run_frame(2'b01, 0, 1'b0, 1'b0);
    run_frame(2'b11, 0, 1'b0, 1'b0);

    // Invert, then a stalled frame with a start pulse while busy.
    for (int i = 0; i < N; i++) ram[i] = 12'($urandom);
    run_frame(2'b10, 0, 1'b0, 1'b0);
    run_frame(2'b00, 2, 1'b0, 1'b1);

    // Three back-to-back frames, random ready, mode_sel toggled mid-frame.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) ram[i] = 12'($urandom);
      run_frame(2'($urandom), 1, 1'b1, f == 1);
    end

    // One-cycle reset mid-frame, then a full frame.
    mon_on = 1'b0;
    start = 1'b1;
    mode_sel = 2'b01;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    exp_q.delete();
    mon_on = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);
    for (int i = 0; i < N; i++) ram[i] = 12'($urandom);
    run_frame(2'b11, 1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_stream_ctrl.md
# filter_stream_ctrl

Frame-scan controller that sequences the 12-bit RGB444 filter datapath. On a start pulse it reads one full frame from a synchronous frame-buffer RAM in raster order. Each pixel passes through the filter mode latched at frame start. The results are emitted on a valid/ready pixel stream with start-of-frame and end-of-line markers. It sits between the frame buffer and the VGA/output formatter and makes the combinational grayscale_filter usable under backpressure.

## Interface
Parameters:
- H_PIX, 320, pixels per line
- V_PIX, 240, lines per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_PIX*V_PIX
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥ 2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle frame request; ignored while busy
- mode_sel  in  2  00 bypass, 01 grayscale, 10 invert, 11 grayscale+invert
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last pixel handshake
- mem_en  out  1  frame-buffer read enable
- mem_addr  out  ADDR_W  read address, raster order, starting at 0
- mem_rdata  in  12  {R,G,B} 4 bits each; valid exactly 1 cycle after mem_en
- pix_out  out  12  filtered pixel {R,G,B}
- pix_valid  out  1  pix_out, pix_sof and pix_eol are valid
- pix_ready  in  1  downstream accepts; transfer when pix_valid && pix_ready
- pix_sof  out  1  high with pixel (0,0)
- pix_eol  out  1  high with the last pixel of each line

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on start.
  - RUN → DRAIN after the read of address H_PIX*V_PIX−1 is issued.
  - DRAIN → IDLE on the handshake of the last pixel, with done pulsing in the following cycle.
- mode_sel is latched on the start cycle. Changes during a frame have no effect until the next frame.
- Read issue in RUN: mem_en = 1 only when fifo_count + inflight < FIFO_DEPTH (inflight ∈ {0,1}). The address increments after each issued read. The x/y counters wrap x at H_PIX−1 and increment y.
- Each returned word is filtered combinationally and written to the FIFO together with its sof/eol flags. Tags travel with the read, one cycle delayed.
- Filter arithmetic:
  - grayscale: g = (max(R,G,B) + min(R,G,B)) >> 1, using a 5-bit sum with no overflow. The result is replicated on all three channels.
  - invert: each channel becomes 15 − c.
  - mode 11: grayscale first, then invert.
- The FIFO is never written when full, because the credit check guarantees space. It is never read when empty. Simultaneous write and read keeps the count unchanged.
- start while busy is ignored with no side effects.
- Reset values: busy 0, done 0, mem_en 0, mem_addr 0, pix_valid 0, pix_sof 0, pix_eol 0, pix_out 0. Reset also clears the FIFO and counters. Reset mid-frame abandons the frame, and no done pulse is emitted.

## Timing
- Start is sampled at edge T. busy and the first mem_en (addr 0) occur in cycle T+1. The FIFO write happens in cycle T+2. pix_valid is first high in cycle T+3.
- With pix_ready held at 1, throughput is one pixel per cycle and there are no bubbles after the first.
- With the last handshake in cycle L, done = 1 and busy = 0 in cycle L+1. A new start is accepted in cycle L+1.
- While pix_ready = 0, pix_out and all flags are held stable. After at most FIFO_DEPTH reads are outstanding/buffered, mem_en stays 0.
- Frame length is always exactly H_PIX*V_PIX pixels. pix_eol occurs exactly V_PIX times and pix_sof exactly once.

## Structure
- Package filter_stream_pkg holds:
  - typedef mode_e (BYPASS, GRAY, INVERT, GRAY_INV)
  - typedef state_e (IDLE, RUN, DRAIN)
  - typedef struct rgb444_t {r, g, b}
  - the pixel-filter function shared with grayscale_filter
- One sub-module: pixel_fifo, a synchronous FIFO of width 14 (pixel + sof + eol) and depth FIFO_DEPTH, with count output.

## Test plan
All scenarios use H_PIX=4, V_PIX=2, and the RAM holds word i at address i.
- Bypass, ready = 1: start at T. The stream is words 0..7, with pix_valid from T+3. sof on the first pixel, eol on pixels 3 and 7, done in the cycle after pixel 7.
- Grayscale: RAM word 12'hF30 → pix_out 12'h777; word 12'h000 → 12'h000. Mode 11 with 12'hF30 → 12'h888.
- Backpressure: drop pix_ready for 10 cycles mid-frame. pix_out is held stable, mem_en stops after FIFO_DEPTH outstanding, no pixels are lost or duplicated, and the order is preserved.
- Random pix_ready (50%) over 3 back-to-back frames: each frame has 8 pixels, one sof, and two eol. Toggling mode_sel mid-frame does not affect the current frame.
- Start pulsed while busy: ignored, with exactly one done per frame.
- rst_n low for 1 cycle mid-frame: all outputs are at reset values in the next cycle, no done is emitted, and a subsequent start produces a full correct frame.
